velocity_filter_scheduler: RTL

VELOCITY_FILTER_SCHEDULER -- requirements
Module: velocity_filter_scheduler

---
 rtl/velocity_filter_scheduler.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/velocity_filter_scheduler.sv
// velocity_filter_scheduler
//   Round-robin scheduler that shares one noise-filter engine between NUM_REQ
//   requesting channels. A granted channel gets a one-cycle engine start. The
//   engine result is captured when eng_valid_i arrives, and the owning channel
//   then receives a one-cycle done pulse.
//
//   Build option: define NF_WATCHDOG_EN to enable the WAIT-state watchdog. When
//   it is enabled, a silent engine is abandoned after TIMEOUT_CYCLES. The
//   transaction then completes with result_out_o = 0 and result_err_o = 1, and
//   err_count_o increments (saturating at 255). When the macro is undefined,
//   WAIT lasts until the engine answers, and result_err_o and err_count_o are
//   tied to 0.
//
// Ports
//   clk_i         clock, rising edge
//   reset_i       asynchronous active-high reset
//   req_i         per-channel request, held until the matching done bit
//   grant_o       one-hot owner of the engine (zero when idle)
//   eng_start_o   one-cycle engine start pulse
//   eng_chan_o    index of the granted channel
//   eng_busy_i    engine busy flag (informational, never gates the FSM)
//   eng_valid_i   engine result-valid pulse
//   eng_result_i  eight packed 8-bit peak bins
//   done_o        one-cycle completion pulse to the owning channel
//   result_out_o  last captured result
//   result_err_o  high with done_o when the transaction timed out
//   err_count_o   saturating timeout count
module velocity_filter_scheduler #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [NUM_REQ-1:0] req_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic               eng_start_o,
   output logic [1:0]         eng_chan_o,
   input  logic               eng_busy_i,
   input  logic               eng_valid_i,
   input  logic [63:0]        eng_result_i,
   output logic [NUM_REQ-1:0] done_o,
   output logic [63:0]        result_out_o,
   output logic               result_err_o,
   output logic [7:0]         err_count_o
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {StIdle, StStart, StWait, StDeliver} state_e;

   state_e              state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [IdxW-1:0]     chan_q, chan_d;
   logic [IdxW-1:0]     last_q, last_d;
   logic [63:0]         result_q, result_d;

   logic                pick_vld;
   logic [IdxW-1:0]     pick_idx;

   // The busy flag is observed only; it never affects a transition.
   logic                unused_busy;
   assign unused_busy = eng_busy_i;

`ifdef NF_WATCHDOG_EN
   localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

   logic [WdW-1:0]      wd_cnt_q;
   logic                err_q;
   logic [7:0]          err_cnt_q;
   logic                wd_fire;

   // An engine answer on the final WAIT cycle wins over the timeout.
   assign wd_fire = (state_q == StWait) && !eng_valid_i &&
                    (wd_cnt_q == WdW'(TIMEOUT_CYCLES - 1));
`endif

   // Round-robin pick: search upward from last_q+1 with wrap.
   always_comb begin
      int unsigned idx;
      idx      = 0;
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         idx = (32'(last_q) + off) % NUM_REQ;
         if (!pick_vld && req_i[idx[IdxW-1:0]]) begin
            pick_vld = 1'b1;
            pick_idx = idx[IdxW-1:0];
         end
      end
   end

   // Next-state and outputs.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      chan_d      = chan_q;
      last_d      = last_q;
      result_d    = result_q;
      eng_start_o = 1'b0;
      done_o      = '0;

      unique case (state_q)
         StIdle: begin
            if (pick_vld) begin
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               chan_d            = pick_idx;
               state_d           = StStart;
            end
         end
         StStart: begin
            eng_start_o = 1'b1;
            state_d     = StWait;
         end
         StWait: begin
            if (eng_valid_i) begin
               result_d = eng_result_i;
               state_d  = StDeliver;
            end
`ifdef NF_WATCHDOG_EN
            else if (wd_fire) begin
               result_d = '0;
               state_d  = StDeliver;
            end
`endif
         end
         StDeliver: begin
            done_o  = grant_q;
            last_d  = chan_q;
            grant_d = '0;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= StIdle;
         grant_q  <= '0;
         chan_q   <= '0;
         last_q   <= IdxW'(NUM_REQ - 1);
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         chan_q   <= chan_d;
         last_q   <= last_d;
         result_q <= result_d;
      end
   end

`ifdef NF_WATCHDOG_EN
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wd_cnt_q  <= '0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         // Counter restarts from 0 on every entry to WAIT.
         if (state_q == StWait) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
         end else begin
            wd_cnt_q <= '0;
         end
         if (state_q == StWait && eng_valid_i) begin
            err_q <= 1'b0;
         end else if (wd_fire) begin
            err_q <= 1'b1;
            if (err_cnt_q != 8'hFF) begin
               err_cnt_q <= err_cnt_q + 8'd1;
            end
         end
      end
   end

   assign result_err_o = (state_q == StDeliver) & err_q;
   assign err_count_o  = err_cnt_q;
`else
   assign result_err_o = 1'b0;
   assign err_count_o  = 8'd0;
`endif

   assign grant_o      = grant_q;
   assign eng_chan_o   = 2'(chan_q);
   assign result_out_o = result_q;

endmodule
